// File: rtl/gate_chain_tester_if.sv
// gate_chain_tester_if: stimulus/response bundle between the tester and the gate chain
interface gate_chain_tester_if;
  logic dut_a, dut_b, dut_c, dut_d, dut_e, dut_f, dut_g;
  modport master(output dut_a, dut_b, dut_c, dut_d, input dut_e, dut_f, dut_g);
  modport slave(input dut_a, dut_b, dut_c, dut_d, output dut_e, dut_f, dut_g);
endinterface

// File: rtl/gate_chain_tester.sv
// gate_chain_tester: built-in self-test that sweeps all 16 vectors through the gate chain
module gate_chain_tester #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  gate_chain_tester_if.master  chain,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [3:0]           first_fail_vec,
  output logic                 first_fail_valid
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] vec_q, vec_d, stim_q, stim_d, ffv_q, ffv_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic ffval_q, ffval_d, gold_e, gold_f, gold_g, mism;
  assign gold_e = ~(vec_q[3] & vec_q[2]);
  assign gold_f = ~(gold_e & vec_q[1]);
  assign gold_g = ~gold_f & vec_q[0];
  assign mism = {chain.dut_e, chain.dut_f, chain.dut_g} != {gold_e, gold_f, gold_g};
  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    cnt_d = cnt_q;
    err_d = err_q;
    ffv_d = ffv_q;
    ffval_d = ffval_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = SETTLE;
        vec_d = '0;
        cnt_d = '0;
        err_d = '0;
        ffv_d = '0;
        ffval_d = 1'b0;
      end
      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) state_d = CHECK;
      end
      CHECK: begin
        if (mism) begin
          err_d = &err_q ? err_q : err_q + 1'b1;
          if (!ffval_q) begin
            ffv_d = vec_q;
            ffval_d = 1'b1;
          end
        end
        state_d = &vec_q ? DONE : SETTLE;
        vec_d = &vec_q ? vec_q : vec_q + 1'b1;
        cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
    // stimulus register tracks the next vector so the chain sees it on entry to SETTLE
    stim_d = state_d == IDLE ? 4'd0 : vec_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q <= '0;
      stim_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
      ffv_q <= '0;
      ffval_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
      stim_q <= stim_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      ffv_q <= ffv_d;
      ffval_q <= ffval_d;
    end
  end
  assign chain.dut_a = stim_q[3];
  assign chain.dut_b = stim_q[2];
  assign chain.dut_c = stim_q[1];
  assign chain.dut_d = stim_q[0];
  assign busy = state_q == SETTLE || state_q == CHECK;
  assign done = state_q == DONE;
  assign pass = done && err_q == '0;
  assign err_count = err_q;
  assign first_fail_vec = ffv_q;
  assign first_fail_valid = ffval_q;
endmodule
